// File: rtl/led_tick_sequencer.sv
// led_tick_sequencer: sole Avalon-MM master of the interval timer; starts it, clears each timeout and steps an LED pattern.
// Optional feature macro LED_TICK_SEQ_PRESCALE_EN: pattern steps only once every PRESCALE serviced interrupts.
module led_tick_sequencer #(
   parameter int LED_WIDTH = 8
`ifdef LED_TICK_SEQ_PRESCALE_EN
   ,
   parameter int PRESCALE = 4
`endif
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 irq,
   input  logic [1:0]           mode,
   output logic [2:0]           tmr_address,
   output logic                 tmr_chipselect,
   output logic                 tmr_write_n,
   output logic [15:0]          tmr_writedata,
   output logic [LED_WIDTH-1:0] led,
   output logic [15:0]          tick_count
);

   typedef enum logic [1:0] {S_INIT, S_IDLE, S_CLEAR, S_HOLDOFF} state_t;

   localparam logic [1:0]  MODE_WALK    = 2'd0;
   localparam logic [1:0]  MODE_BOUNCE  = 2'd1;
   localparam logic [1:0]  MODE_COUNT   = 2'd2;
   localparam logic [2:0]  ADDR_STATUS  = 3'd0;
   localparam logic [2:0]  ADDR_CONTROL = 3'd1;
   localparam logic [15:0] CTRL_START   = 16'h0007;
   localparam logic [15:0] STATUS_CLEAR = 16'h0000;
   localparam logic [LED_WIDTH-1:0] LED_ONE = LED_WIDTH'(1);

   state_t               r_state;
   state_t               w_next;
   logic                 r_cs;
   logic                 r_wr_n;
   logic [2:0]           r_addr;
   logic [15:0]          r_wdat;
   logic                 w_cs;
   logic                 w_wr_n;
   logic [2:0]           w_addr;
   logic [15:0]          w_wdat;
   logic [LED_WIDTH-1:0] r_led;
   logic [LED_WIDTH-1:0] w_led_next;
   logic                 r_dir_down;
   logic                 w_dir_next;
   logic                 r_seeded;
   logic [1:0]           r_last_mode;
   logic [15:0]          r_tick;
   logic                 w_reseed;
   logic                 w_step;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state <= S_INIT;
      end else begin
         r_state <= w_next;
      end
   end

   // HOLDOFF ignores irq so the timer's registered irq fall cannot trigger a second clear.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_INIT:    w_next = S_IDLE;
         S_IDLE:    w_next = irq ? S_CLEAR : S_IDLE;
         S_CLEAR:   w_next = S_HOLDOFF;
         S_HOLDOFF: w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_cs   = 1'b0;
      w_wr_n = 1'b1;
      w_addr = '0;
      w_wdat = '0;
      if (r_state == S_INIT) begin
         w_cs   = 1'b1;
         w_wr_n = 1'b0;
         w_addr = ADDR_CONTROL;
         w_wdat = CTRL_START;
      end else if (w_next == S_CLEAR) begin
         w_cs   = 1'b1;
         w_wr_n = 1'b0;
         w_addr = ADDR_STATUS;
         w_wdat = STATUS_CLEAR;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_cs   <= 1'b0;
         r_wr_n <= 1'b1;
         r_addr <= '0;
         r_wdat <= '0;
      end else begin
         r_cs   <= w_cs;
         r_wr_n <= w_wr_n;
         r_addr <= w_addr;
         r_wdat <= w_wdat;
      end
   end

`ifdef LED_TICK_SEQ_PRESCALE_EN
   localparam logic [7:0] PRE_LAST = 8'(PRESCALE - 1);
   logic [7:0] r_pre_cnt;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_pre_cnt <= '0;
      end else if (r_state == S_CLEAR) begin
         r_pre_cnt <= (r_pre_cnt == PRE_LAST) ? 8'd0 : r_pre_cnt + 8'd1;
      end
   end

   assign w_step = (r_state == S_CLEAR) && (r_pre_cnt == PRE_LAST);
`else
   assign w_step = (r_state == S_CLEAR);
`endif

   // Bounce flips direction on arrival at an end so each end stays lit for a single step.
   always_comb begin
      w_led_next = r_led;
      w_dir_next = r_dir_down;
      w_reseed   = !r_seeded || (mode != r_last_mode);
      if (w_reseed) begin
         case (mode)
            MODE_WALK:   w_led_next = LED_ONE;
            MODE_BOUNCE: begin
               w_led_next = LED_ONE;
               w_dir_next = 1'b0;
            end
            MODE_COUNT:  w_led_next = '0;
            default:     w_led_next = r_led;
         endcase
      end else begin
         case (mode)
            MODE_WALK:   w_led_next = {r_led[LED_WIDTH-2:0], r_led[LED_WIDTH-1]};
            MODE_BOUNCE: begin
               if (!r_dir_down) begin
                  w_led_next = r_led << 1;
                  w_dir_next = w_led_next[LED_WIDTH-1];
               end else begin
                  w_led_next = r_led >> 1;
                  w_dir_next = !w_led_next[0];
               end
            end
            MODE_COUNT:  w_led_next = r_led + LED_ONE;
            default:     w_led_next = r_led;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_led       <= '0;
         r_tick      <= '0;
         r_seeded    <= 1'b0;
         r_dir_down  <= 1'b0;
         r_last_mode <= MODE_WALK;
      end else if (r_state == S_CLEAR) begin
         r_tick <= r_tick + 16'd1;
         if (w_step) begin
            r_led       <= w_led_next;
            r_dir_down  <= w_dir_next;
            r_seeded    <= 1'b1;
            r_last_mode <= mode;
         end
      end
   end

   assign tmr_chipselect = r_cs;
   assign tmr_write_n    = r_wr_n;
   assign tmr_address    = r_addr;
   assign tmr_writedata  = r_wdat;
   assign led            = r_led;
   assign tick_count     = r_tick;

endmodule

// File: tb/tb_led_tick_sequencer.sv
// Bench for led_tick_sequencer: randomized irq/mode stimulus against a position-based pattern model.
`timescale 1ns/1ps
module tb_led_tick_sequencer;
   localparam int W  = 8;
   localparam int W4 = 4;
`ifdef LED_TICK_SEQ_PRESCALE_EN
   localparam int PRE = 4;
`else
   localparam int PRE = 1;
`endif

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        irq = 1'b0;
   logic [1:0]  mode = 2'd0;
   logic [2:0]  tmr_address, tmr_address4;
   logic        tmr_chipselect, tmr_chipselect4;
   logic        tmr_write_n, tmr_write_n4;
   logic [15:0] tmr_writedata, tmr_writedata4;
   logic [W-1:0]  led;
   logic [W4-1:0] led4;
   logic [15:0] tick_count, tick_count4;

   int n_tests = 0;
   int n_fail  = 0;
   int n_clear = 0, n_init = 0, n_bad = 0, n_clear4 = 0;

   // reference model state
   int   m_led, m_tick, m_wpos, m_bidx, m_pre;
   bit   m_seeded;
   logic [1:0] m_last;

   always #5 clk = ~clk;

   led_tick_sequencer #(.LED_WIDTH(W)) dut (
      .clk(clk), .reset_n(reset_n), .irq(irq), .mode(mode),
      .tmr_address(tmr_address), .tmr_chipselect(tmr_chipselect),
      .tmr_write_n(tmr_write_n), .tmr_writedata(tmr_writedata),
      .led(led), .tick_count(tick_count));

   led_tick_sequencer #(.LED_WIDTH(W4)) dut4 (
      .clk(clk), .reset_n(reset_n), .irq(irq), .mode(mode),
      .tmr_address(tmr_address4), .tmr_chipselect(tmr_chipselect4),
      .tmr_write_n(tmr_write_n4), .tmr_writedata(tmr_writedata4),
      .led(led4), .tick_count(tick_count4));

   always @(negedge clk) begin
      if (tmr_chipselect !== !tmr_write_n) n_bad++;
      else if (tmr_chipselect) begin
         if (tmr_address == 3'd0 && tmr_writedata == 16'h0000) n_clear++;
         else if (tmr_address == 3'd1 && tmr_writedata == 16'h0007) n_init++;
         else n_bad++;
      end
      if (tmr_chipselect4 && !tmr_write_n4 && tmr_address4 == 3'd0) n_clear4++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_led = 0; m_tick = 0; m_wpos = 0; m_bidx = 0; m_pre = 0;
      m_seeded = 0; m_last = 2'd0;
   endtask

   task automatic model_clear(input logic [1:0] md);
      bit do_step;
      int pos;
      m_tick = (m_tick + 1) % 65536;
      m_pre  = m_pre + 1;
      do_step = (m_pre == PRE);
      if (do_step) m_pre = 0;
      if (do_step) begin
         if (!m_seeded || md != m_last) begin
            case (md)
               2'd0: begin m_wpos = 0; m_led = 1; end
               2'd1: begin m_bidx = 0; m_led = 1; end
               2'd2: m_led = 0;
               default: ;
            endcase
         end else begin
            case (md)
               2'd0: begin m_wpos = (m_wpos + 1) % W; m_led = 1 << m_wpos; end
               2'd1: begin
                  m_bidx = (m_bidx + 1) % (2 * (W - 1));
                  pos = (m_bidx < W) ? m_bidx : 2 * (W - 1) - m_bidx;
                  m_led = 1 << pos;
               end
               2'd2: m_led = (m_led + 1) % (1 << W);
               default: ;
            endcase
         end
         m_seeded = 1;
         m_last = md;
      end
   endtask

   // irq high for len sampling edges starting in IDLE, then enough idle cycles to settle
   task automatic irq_burst(input int len);
      irq = 1'b1;
      repeat (len) step();
      irq = 1'b0;
      repeat (3) step();
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      irq = 1'b0;
      repeat (3) step();
      reset_n = 1'b1;
      model_reset();
      repeat (3) step();
   endtask

   task automatic test_reset();
      int init0;
      reset_n = 1'b0;
      repeat (3) step();
      n_tests++;
      if (tmr_chipselect !== 1'b0 || tmr_write_n !== 1'b1 || tmr_address !== 3'd0 || tmr_writedata !== 16'h0) begin
         n_fail++;
         $display("FAIL rst_bus got cs=%b wn=%b a=%0d d=%h exp cs=0 wn=1 a=0 d=0000", tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata);
      end
      n_tests++;
      if (led !== 8'h00 || tick_count !== 16'h0) begin
         n_fail++;
         $display("FAIL rst_state got led=%h tick=%0d exp led=00 tick=0", led, tick_count);
      end
      init0 = n_init;
      reset_n = 1'b1;
      model_reset();
      step();
      n_tests++;
      if (tmr_chipselect !== 1'b1 || tmr_write_n !== 1'b0 || tmr_address !== 3'd1 || tmr_writedata !== 16'h0007) begin
         n_fail++;
         $display("FAIL init_write got cs=%b wn=%b a=%0d d=%h exp cs=1 wn=0 a=1 d=0007", tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata);
      end
      step();
      n_tests++;
      if (tmr_chipselect !== 1'b0 || tmr_write_n !== 1'b1) begin
         n_fail++;
         $display("FAIL post_init_idle got cs=%b wn=%b exp cs=0 wn=1", tmr_chipselect, tmr_write_n);
      end
      repeat (3) step();
      n_tests++;
      if (n_init - init0 !== 1) begin
         n_fail++;
         $display("FAIL init_count got %0d exp 1", n_init - init0);
      end
   endtask

   task automatic test_walk();
      int c0;
      logic [W-1:0] exp;
      c0 = n_clear;
      mode = 2'd0;
      for (int i = 0; i < 10; i++) begin
         irq_burst(1);
         model_clear(mode);
         n_tests++;
         if (led !== W'(m_led)) begin
            n_fail++;
            $display("FAIL walk_led[%0d] got %h exp %h", i, led, W'(m_led));
         end
`ifndef LED_TICK_SEQ_PRESCALE_EN
         exp = 8'h01 << (i % 8);
         n_tests++;
         if (led !== exp) begin
            n_fail++;
            $display("FAIL walk_table[%0d] got %h exp %h", i, led, exp);
         end
`endif
      end
      n_tests++;
      if (tick_count !== 16'd10 || n_clear - c0 !== 10) begin
         n_fail++;
         $display("FAIL walk_ticks got tick=%0d clears=%0d exp 10/10", tick_count, n_clear - c0);
      end
   endtask

   task automatic test_bounce_mode_change();
      int bt[16] = '{1, 2, 4, 8, 4, 2, 1, 2, 4, 8, 4, 2, 1, 2, 4, 8};
      logic [W4-1:0] e4;
      mode = 2'd1;
      for (int i = 0; i < 16; i++) begin
         irq_burst(1);
         model_clear(mode);
         n_tests++;
         if (led !== W'(m_led)) begin
            n_fail++;
            $display("FAIL bounce_led[%0d] got %h exp %h", i, led, W'(m_led));
         end
`ifndef LED_TICK_SEQ_PRESCALE_EN
         e4 = W4'(bt[i]);
         n_tests++;
         if (led4 !== e4) begin
            n_fail++;
            $display("FAIL bounce4_led[%0d] got %h exp %h", i, led4, e4);
         end
`endif
      end
      mode = 2'd2;
      for (int i = 0; i < 3; i++) begin
         irq_burst(1);
         model_clear(mode);
         n_tests++;
         if (led !== W'(m_led)) begin
            n_fail++;
            $display("FAIL modechg_led[%0d] got %h exp %h", i, led, W'(m_led));
         end
`ifndef LED_TICK_SEQ_PRESCALE_EN
         e4 = W4'(i);
         n_tests++;
         if (led4 !== e4) begin
            n_fail++;
            $display("FAIL modechg4_led[%0d] got %h exp %h", i, led4, e4);
         end
`endif
      end
   endtask

   task automatic test_count_wrap();
      do_reset();
      mode = 2'd2;
      for (int i = 0; i < 257; i++) begin
         irq_burst(1);
         model_clear(mode);
         n_tests++;
         if (led !== W'(m_led)) begin
            n_fail++;
            $display("FAIL count_led[%0d] got %h exp %h", i, led, W'(m_led));
         end
`ifndef LED_TICK_SEQ_PRESCALE_EN
         if (i == 0 || i == 256) begin
            n_tests++;
            if (led !== 8'h00) begin
               n_fail++;
               $display("FAIL count_wrap_zero[%0d] got %h exp 00", i, led);
            end
         end
`endif
      end
      n_tests++;
      if (tick_count !== 16'd257) begin
         n_fail++;
         $display("FAIL count_ticks got %0d exp 257", tick_count);
      end
   endtask

   task automatic test_back_to_back();
      int c0;
      mode = 2'($urandom_range(0, 3));
      c0 = n_clear;
      irq = 1'b1;
      repeat (12) step();
      irq = 1'b0;
      repeat (3) step();
      for (int i = 0; i < 4; i++) model_clear(mode);
      n_tests++;
      if (n_clear - c0 !== 4) begin
         n_fail++;
         $display("FAIL b2b_clears got %0d exp 4", n_clear - c0);
      end
      n_tests++;
      if (led !== W'(m_led) || tick_count !== 16'(m_tick)) begin
         n_fail++;
         $display("FAIL b2b_state got led=%h tick=%0d exp led=%h tick=%0d", led, tick_count, W'(m_led), m_tick);
      end
   endtask

   task automatic test_reset_in_clear();
      int c0, init0;
      irq = 1'b1;
      step();
      c0 = n_clear;
      reset_n = 1'b0;
      irq = 1'b0;
      repeat (4) step();
      n_tests++;
      if (n_clear !== c0) begin
         n_fail++;
         $display("FAIL rst_clear_write got %0d extra clears exp 0", n_clear - c0);
      end
      init0 = n_init;
      reset_n = 1'b1;
      model_reset();
      step();
      n_tests++;
      if (tmr_chipselect !== 1'b1 || tmr_address !== 3'd1 || tmr_writedata !== 16'h0007) begin
         n_fail++;
         $display("FAIL reinit_write got cs=%b a=%0d d=%h exp cs=1 a=1 d=0007", tmr_chipselect, tmr_address, tmr_writedata);
      end
      repeat (2) step();
      n_tests++;
      if (n_init - init0 !== 1 || led !== 8'h00 || tick_count !== 16'h0) begin
         n_fail++;
         $display("FAIL reinit_state got inits=%0d led=%h tick=%0d exp 1/00/0", n_init - init0, led, tick_count);
      end
   endtask

   task automatic test_random();
      int c0, len, nc;
      for (int i = 0; i < 60; i++) begin
         mode = 2'($urandom_range(0, 3));
         len = $urandom_range(1, 10);
         nc = (len + 2) / 3;
         c0 = n_clear;
         irq_burst(len);
         for (int k = 0; k < nc; k++) model_clear(mode);
         n_tests++;
         if (led !== W'(m_led) || tick_count !== 16'(m_tick) || n_clear - c0 !== nc) begin
            n_fail++;
            $display("FAIL rand[%0d] mode=%0d len=%0d got led=%h tick=%0d clears=%0d exp led=%h tick=%0d clears=%0d",
                     i, mode, len, led, tick_count, n_clear - c0, W'(m_led), m_tick, nc);
         end
      end
      n_tests++;
      if (tick_count4 !== 16'(m_tick)) begin
         n_fail++;
         $display("FAIL rand_tick4 got %0d exp %0d", tick_count4, m_tick);
      end
   endtask

   initial begin
      test_reset();
      test_walk();
      test_bounce_mode_change();
      test_count_wrap();
      test_back_to_back();
      test_reset_in_clear();
      test_random();
      n_tests++;
      if (n_bad !== 0) begin
         n_fail++;
         $display("FAIL bus_protocol got %0d malformed cycles exp 0", n_bad);
      end
      n_tests++;
      if (n_clear4 !== n_clear) begin
         n_fail++;
         $display("FAIL clear_count_w4 got %0d exp %0d", n_clear4, n_clear);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
